nhap_string_entry: RTL

//  Operator-side front end that builds the search string and the 4-bit pattern consumed by the

---
 rtl/nhap_string_entry.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/nhap_string_entry.sv
// nhap_string_entry: operator front end that builds the search string and the
// pattern consumed by the scan/display block. Buttons are synchronised,
// optionally debounced (define DEBOUNCE_EN), edge-detected, then drive a
// small entry FSM: S_STR -> S_PAT -> S_RDY, with S_CLR reachable from any state.
module nhap_string_entry #(
  parameter int STR_LEN     = 40,
  parameter int PAT_LEN     = 4,
  parameter int ROLL_CYCLES = 4,
  parameter int DEB_CYCLES  = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_bit,
  input  logic [PAT_LEN-1:0] sw_pat,
  input  logic               btn_enter,
  input  logic               btn_next,
  input  logic               btn_clear,
  output logic [0:STR_LEN-1] stringo,
  output logic [7:0]         counter,
  output logic [PAT_LEN-1:0] in_comp,
  output logic               ready,
  output logic               roll_back,
  output logic               full
);

  localparam logic [7:0] STR_MAX   = 8'(STR_LEN);
  localparam logic [7:0] PAT_MIN   = 8'(PAT_LEN);
  localparam logic [7:0] ROLL_LAST = 8'(ROLL_CYCLES - 1);

  typedef enum logic [1:0] {S_STR, S_PAT, S_RDY, S_CLR} state_e;

  // Button bit order everywhere: [0]=enter, [1]=next, [2]=clear.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q, prev_q;
  logic [2:0] btn_lvl;
  logic [2:0] pulse;

  assign btn_raw = {btn_clear, btn_next, btn_enter};

  // Two-stage synchroniser plus previous-level register for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= btn_lvl;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [2:0]       level_q, level_d;
  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [DEB_W-1:0] deb_cnt_d [3];

  // Accept a new level only after it has differed from the held level for DEB_CYCLES in a row.
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      level_d[b]   = level_q[b];
      deb_cnt_d[b] = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (deb_cnt_q[b] == DEB_LAST) level_d[b] = sync2_q[b];
        else                          deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
      end
    end
  end

  // Debounced level and per-button stability counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      for (int b = 0; b < 3; b++) deb_cnt_q[b] <= '0;
    end else begin
      level_q <= level_d;
      for (int b = 0; b < 3; b++) deb_cnt_q[b] <= deb_cnt_d[b];
    end
  end

  assign btn_lvl = level_q;
`else
  logic deb_unused;
  assign deb_unused = ^DEB_CYCLES;
  assign btn_lvl    = sync2_q;
`endif

  assign pulse = btn_lvl & ~prev_q;

  state_e             state_q, state_d;
  logic [0:STR_LEN-1] stringo_q, stringo_d;
  logic [7:0]         counter_q, counter_d;
  logic [PAT_LEN-1:0] in_comp_q, in_comp_d;
  logic               roll_back_q, roll_back_d;
  logic [7:0]         roll_cnt_q, roll_cnt_d;
  logic               full_c;

  assign full_c = (counter_q == STR_MAX);

  // Entry FSM: clear > next > enter; only the highest-priority pulse acts.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    stringo_d   = stringo_q;
    counter_d   = counter_q;
    in_comp_d   = in_comp_q;
    roll_cnt_d  = roll_cnt_q;
    roll_back_d = 1'b1;
    if (state_q == S_CLR) begin
      if (roll_cnt_q == ROLL_LAST) begin
        state_d = S_STR;
      end else begin
        roll_cnt_d  = roll_cnt_q + 8'd1;
        roll_back_d = 1'b0;
      end
    end else if (pulse[2]) begin
      state_d     = S_CLR;
      stringo_d   = '0;
      counter_d   = '0;
      in_comp_d   = '0;
      roll_cnt_d  = '0;
      roll_back_d = 1'b0;
    end else begin
      case (state_q)
        S_STR: begin
          if (pulse[1]) begin
            if (counter_q >= PAT_MIN) state_d = S_PAT;
          end else if (pulse[0] && !full_c) begin
            for (int i = 0; i < STR_LEN; i++)
              if (8'(i) == counter_q) stringo_d[i] = sw_bit;
            counter_d = counter_q + 8'd1;
          end
        end
        S_PAT: begin
          if (!pulse[1] && pulse[0]) begin
            in_comp_d = sw_pat;
            state_d   = S_RDY;
          end
        end
        default: ;
      endcase
    end
  end

  // State and data registers; reset aborts straight to the idle values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_STR;
      stringo_q   <= '0;
      counter_q   <= '0;
      in_comp_q   <= '0;
      roll_back_q <= 1'b0;
      roll_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stringo_q   <= stringo_d;
      counter_q   <= counter_d;
      in_comp_q   <= in_comp_d;
      roll_back_q <= roll_back_d;
      roll_cnt_q  <= roll_cnt_d;
    end
  end

  assign stringo   = stringo_q;
  assign counter   = counter_q;
  assign in_comp   = in_comp_q;
  assign ready     = (state_q == S_RDY);
  assign roll_back = roll_back_q;
  assign full      = full_c;

endmodule
